fetch_prefetch_queue: RTL

Parametrised instruction-fetch stage with a small prefetch queue between the fetch PC and the IF/ID pipeline register. It runs ahead of decode whenever the queue has space, holds the decode-stage register on `StallD` without losing the instruction, and discards all wrong-path entries on a redirect from Execute. It replaces the single-register fetch stage. The hazard unit no longer needs to drive `StallF`: fetch back-pressure comes from queue occupancy.

---
 rtl/fetch_prefetch_queue_if.sv | 29 ++
 rtl/fetch_prefetch_queue.sv | 98 +++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue_if.sv
// Fetch-stage bundle: instruction memory port plus the decode-side controls and IF/ID register outputs.
// The slave modport is the fetch stage; the master modport is the pipeline/memory side.
interface fetch_prefetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    logic                       PCSrcE;
    logic [XLEN-1:0]            PCTargetE;
    logic                       StallD;
    logic                       FlushD;
    logic [XLEN-1:0]            ImemAddrF;
    logic                       ImemReqF;
    logic [XLEN-1:0]            ImemRdataF;
    logic [XLEN-1:0]            InstrD;
    logic [XLEN-1:0]            PCD;
    logic [XLEN-1:0]            PCPlus4D;
    logic                       validD;
    logic [$clog2(DEPTH+1)-1:0] QueueCount;

    modport slave (
        input  PCSrcE, PCTargetE, StallD, FlushD, ImemRdataF,
        output ImemAddrF, ImemReqF, InstrD, PCD, PCPlus4D, validD, QueueCount
    );

    modport master (
        output PCSrcE, PCTargetE, StallD, FlushD, ImemRdataF,
        input  ImemAddrF, ImemReqF, InstrD, PCD, PCPlus4D, validD, QueueCount
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch with a circular prefetch queue feeding the IF/ID register.
// Back-pressure comes from queue occupancy; a redirect from Execute discards all queued wrong-path entries.
module fetch_prefetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fetch_prefetch_queue_if.slave  bus
);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH+1);

    logic [XLEN-1:0] pcF;
    logic [XLEN-1:0] qPc    [DEPTH];
    logic [XLEN-1:0] qInstr [DEPTH];
    logic [PTRW-1:0] rdPtr;
    logic [PTRW-1:0] wrPtr;
    logic [CNTW-1:0] count;
    logic            pop;
    logic            push;

    logic [XLEN-1:0] instrD;
    logic [XLEN-1:0] pcD;
    logic [XLEN-1:0] pcPlus4D;
    logic            validD;

    // Both decisions use pre-edge occupancy, so a full queue can still accept a fetch while popping.
    assign pop  = !bus.StallD && !bus.PCSrcE && (count != '0);
    assign push = !bus.PCSrcE && ((count < CNTW'(DEPTH)) || pop);

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            qPc[wrPtr]    <= pcF;
            qInstr[wrPtr] <= bus.ImemRdataF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcF   <= RESET_PC;
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (bus.PCSrcE) begin
            pcF   <= bus.PCTargetE;
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTRW'(1);
                pcF   <= pcF + XLEN'(4);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTRW'(1);
            end
            if (push && !pop) begin
                count <= count + CNTW'(1);
            end else if (pop && !push) begin
                count <= count - CNTW'(1);
            end
        end
    end

    // A flush still consumes the popped entry; it simply never reaches decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instrD   <= '0;
            pcD      <= '0;
            pcPlus4D <= '0;
            validD   <= 1'b0;
        end else if (bus.PCSrcE || bus.FlushD) begin
            instrD <= '0;
            validD <= 1'b0;
        end else if (bus.StallD) begin
            instrD <= instrD;
        end else if (pop) begin
            instrD   <= qInstr[rdPtr];
            pcD      <= qPc[rdPtr];
            pcPlus4D <= qPc[rdPtr] + XLEN'(4);
            validD   <= 1'b1;
        end else begin
            instrD <= '0;
            validD <= 1'b0;
        end
    end

    assign bus.ImemAddrF  = pcF;
    assign bus.ImemReqF   = push;
    assign bus.QueueCount = count;
    assign bus.InstrD     = instrD;
    assign bus.PCD        = pcD;
    assign bus.PCPlus4D   = pcPlus4D;
    assign bus.validD     = validD;
endmodule
